// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write side: register count,
// address width, the zero-register index and a storage-mask helper.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd31;

  // Registers that may actually be written; the zero register is excluded
  // when it is hardwired.
  function automatic logic [NUM_REGS-1:0] storage_mask(input logic zero_en);
    logic [NUM_REGS-1:0] m;
    m = {NUM_REGS{1'b1}};
    if (zero_en) begin
      m[ZERO_REG] = 1'b0;
    end else begin
      m = {NUM_REGS{1'b1}};
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_write_port_if.sv
// Write-request handshake bundle: valid/ready plus destination and data.
interface regfile_write_port_if #(
  parameter int WIDTH = 64
);
  logic                  wr_valid;
  logic                  wr_ready;
  regfile_pkg::reg_addr_t wr_addr;
  logic [WIDTH-1:0]      wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_port_decoder.sv
// 5:32 one-hot decoder built as a 2:4 stage selecting one of four 3:8
// decoders; mirrors the tree of the 32:1 read mux.
module decoder2_4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] y
);
  // Enabled 2:4 one-hot decode
  always_comb begin
    y = 4'b0000;
    if (en) begin
      case (sel)
        2'd0:    y = 4'b0001;
        2'd1:    y = 4'b0010;
        2'd2:    y = 4'b0100;
        2'd3:    y = 4'b1000;
        default: y = 4'b0000;
      endcase
    end else begin
      y = 4'b0000;
    end
  end
endmodule

module decoder3_8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] y
);
  // Enabled 3:8 one-hot decode
  always_comb begin
    y = 8'h00;
    if (en) begin
      case (sel)
        3'd0:    y = 8'h01;
        3'd1:    y = 8'h02;
        3'd2:    y = 8'h04;
        3'd3:    y = 8'h08;
        3'd4:    y = 8'h10;
        3'd5:    y = 8'h20;
        3'd6:    y = 8'h40;
        3'd7:    y = 8'h80;
        default: y = 8'h00;
      endcase
    end else begin
      y = 8'h00;
    end
  end
endmodule

module decoder5_32 (
  input  logic [4:0]  sel,
  input  logic        en,
  output logic [31:0] y
);
  logic [3:0] grp_en_s;

  decoder2_4 u_top (
    .sel (sel[4:3]),
    .en  (en),
    .y   (grp_en_s)
  );

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    decoder3_8 u_leaf (
      .sel (sel[2:0]),
      .en  (grp_en_s[g]),
      .y   (y[g*8 +: 8])
    );
  end
endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32-entry register file: valid/ready accept stage,
// one-cycle commit into storage, dirty bitmap and commit counter.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 31 to zero.
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_write_port_if.slave       wr,
  output logic [NUM_REGS*WIDTH-1:0] regs_flat,
  output logic [NUM_REGS-1:0]       wr_onehot,
  output logic                      pend_valid,
  output reg_addr_t                 pend_addr,
  output logic [WIDTH-1:0]          pend_data,
  output logic [NUM_REGS-1:0]       dirty,
  input  logic                      clear_dirty,
  output logic [CNT_W-1:0]          commit_cnt
);

`ifdef REGFILE_ZERO_REG_EN
  localparam logic ZERO_EN = 1'b1;
`else
  localparam logic ZERO_EN = 1'b0;
`endif

  localparam logic [NUM_REGS-1:0] WRITE_MASK = storage_mask(ZERO_EN);

  logic                  accept_s;
  logic                  zero_hit_s;
  logic [NUM_REGS-1:0]   dec_onehot_s;
  logic [NUM_REGS-1:0]   commit_mask_s;
  logic                  commit_s;

  logic                  pend_valid_r;
  reg_addr_t             pend_addr_r;
  logic [WIDTH-1:0]      pend_data_r;
  logic [NUM_REGS-1:0]   wr_onehot_r;
  logic [NUM_REGS-1:0]   dirty_r;
  logic [CNT_W-1:0]      commit_cnt_r;
  logic [WIDTH-1:0]      regs_r [NUM_REGS];

  // Ready is held low only while reset is asserted so the first cycle after
  // reset can already accept.
  assign wr.wr_ready = ~reset;

  // Accept qualification and commit-side enables
  always_comb begin
    accept_s      = 1'b0;
    zero_hit_s    = 1'b0;
    commit_mask_s = {NUM_REGS{1'b0}};
    commit_s      = 1'b0;
    if (wr.wr_valid && !reset) begin
      accept_s   = 1'b1;
      zero_hit_s = ZERO_EN && (wr.wr_addr == ZERO_REG);
    end else begin
      accept_s   = 1'b0;
      zero_hit_s = 1'b0;
    end
    commit_mask_s = wr_onehot_r & WRITE_MASK;
    commit_s      = |wr_onehot_r;
  end

  decoder5_32 u_dec (
    .sel (wr.wr_addr),
    .en  (accept_s),
    .y   (dec_onehot_s)
  );

  // Accept stage: capture the request and its decoded enable for next cycle's commit
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_r <= 1'b0;
      pend_addr_r  <= 5'd0;
      pend_data_r  <= {WIDTH{1'b0}};
      wr_onehot_r  <= {NUM_REGS{1'b0}};
    end else begin
      wr_onehot_r  <= dec_onehot_s;
      pend_valid_r <= accept_s & ~zero_hit_s;
      if (accept_s) begin
        pend_addr_r <= wr.wr_addr;
        pend_data_r <= wr.wr_data;
      end else begin
        pend_addr_r <= pend_addr_r;
        pend_data_r <= pend_data_r;
      end
    end
  end

  // Commit stage: the only path that writes storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_mask_s[i]) begin
          regs_r[i] <= pend_data_r;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Dirty bitmap and commit counter; a commit coinciding with a clear survives
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty_r      <= {NUM_REGS{1'b0}};
      commit_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (clear_dirty) begin
        dirty_r <= commit_mask_s;
      end else begin
        dirty_r <= dirty_r | commit_mask_s;
      end
      if (commit_s) begin
        commit_cnt_r <= commit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        commit_cnt_r <= commit_cnt_r;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    if (ZERO_EN && (i == int'(ZERO_REG))) begin : g_zero
      assign regs_flat[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
    end else begin : g_store
      assign regs_flat[i*WIDTH +: WIDTH] = regs_r[i];
    end
  end

  assign wr_onehot  = wr_onehot_r;
  assign pend_valid = pend_valid_r;
  assign pend_addr  = pend_addr_r;
  assign pend_data  = pend_data_r;
  assign dirty      = dirty_r;
  assign commit_cnt = commit_cnt_r;

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed, table-driven bench for regfile_write_port (default 64-bit data,
// 16-bit counter). Expectations follow REGFILE_ZERO_REG_EN when defined.
module tb_regfile_write_port;

  localparam int WIDTH = 64;
  localparam int CNT_W = 16;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        clr;
    logic [4:0]  idx;
    logic [63:0] e_slice;
    logic [31:0] e_oh;
    logic        e_pv;
    logic [31:0] e_dirty;
    logic [15:0] e_cnt;
  } vec_t;

  logic                 clk;
  logic                 reset;
  logic                 clear_dirty;
  logic [32*WIDTH-1:0]  regs_flat;
  logic [31:0]          wr_onehot;
  logic                 pend_valid;
  logic [4:0]           pend_addr;
  logic [WIDTH-1:0]     pend_data;
  logic [31:0]          dirty;
  logic [CNT_W-1:0]     commit_cnt;

  int tests;
  int fails;
  vec_t vecs[$];

  regfile_write_port_if #(.WIDTH(WIDTH)) bus ();

  regfile_write_port #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (bus),
    .regs_flat   (regs_flat),
    .wr_onehot   (wr_onehot),
    .pend_valid  (pend_valid),
    .pend_addr   (pend_addr),
    .pend_data   (pend_data),
    .dirty       (dirty),
    .clear_dirty (clear_dirty),
    .commit_cnt  (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v, input logic [4:0] a,
                              input logic [63:0] d, input logic c, input logic [4:0] ix,
                              input logic [63:0] es, input logic [31:0] eo, input logic ep,
                              input logic [31:0] ed, input logic [15:0] ec);
    vec_t t;
    t.rst = r; t.vld = v; t.addr = a; t.data = d; t.clr = c; t.idx = ix;
    t.e_slice = es; t.e_oh = eo; t.e_pv = ep; t.e_dirty = ed; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic drive(input logic r, input logic v, input logic [4:0] a,
                       input logic [63:0] d, input logic c);
    reset        = r;
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    clear_dirty  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] all_dirty;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = 64'd0;
    clear_dirty  = 1'b0;

    // Test 1: reset then write 5 = DEAD_BEEF
    vecs.push_back(mk(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 64'd0, 32'h0, 1'b0, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd5, 64'd0, 32'h0000_0020, 1'b1, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd5, 64'hDEAD_BEEF, 32'h0, 1'b0, 32'h0000_0020, 16'd1));
    // Test 2: back-to-back writes to register 3, last wins
    vecs.push_back(mk(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 64'd0, 32'h0, 1'b0, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd3, 64'h11, 1'b0, 5'd3, 64'd0, 32'h0000_0008, 1'b1, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd3, 64'h22, 1'b0, 5'd3, 64'h11, 32'h0000_0008, 1'b1, 32'h0000_0008, 16'd1));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd3, 64'h22, 32'h0, 1'b0, 32'h0000_0008, 16'd2));
    // Test 3: write register 31
    vecs.push_back(mk(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd31, 64'd0, 32'h0, 1'b0, 32'h0, 16'd0));
`ifdef REGFILE_ZERO_REG_EN
    vecs.push_back(mk(1'b0, 1'b1, 5'd31, 64'hFF, 1'b0, 5'd31, 64'd0, 32'h8000_0000, 1'b0, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd31, 64'd0, 32'h0, 1'b0, 32'h0, 16'd1));
`else
    vecs.push_back(mk(1'b0, 1'b1, 5'd31, 64'hFF, 1'b0, 5'd31, 64'd0, 32'h8000_0000, 1'b1, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd31, 64'hFF, 32'h0, 1'b0, 32'h8000_0000, 16'd1));
`endif
    // Test 4: build dirty = 0x0F00, then clear coinciding with commit of reg 7
    vecs.push_back(mk(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd8, 64'd0, 32'h0, 1'b0, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd8, 64'd1, 1'b0, 5'd8, 64'd0, 32'h0000_0100, 1'b1, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd9, 64'd2, 1'b0, 5'd8, 64'd1, 32'h0000_0200, 1'b1, 32'h0000_0100, 16'd1));
    vecs.push_back(mk(1'b0, 1'b1, 5'd10, 64'd3, 1'b0, 5'd9, 64'd2, 32'h0000_0400, 1'b1, 32'h0000_0300, 16'd2));
    vecs.push_back(mk(1'b0, 1'b1, 5'd11, 64'd4, 1'b0, 5'd10, 64'd3, 32'h0000_0800, 1'b1, 32'h0000_0700, 16'd3));
    vecs.push_back(mk(1'b0, 1'b1, 5'd7, 64'd5, 1'b0, 5'd11, 64'd4, 32'h0000_0080, 1'b1, 32'h0000_0F00, 16'd4));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'd5, 32'h0, 1'b0, 32'h0000_0080, 16'd5));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'd5, 32'h0, 1'b0, 32'h0, 16'd5));
    // Test 5: accept a write, then reset before it commits
    vecs.push_back(mk(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd9, 64'd0, 32'h0, 1'b0, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd9, 64'h55, 1'b0, 5'd9, 64'd0, 32'h0000_0200, 1'b1, 32'h0, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd9, 64'd0, 32'h0, 1'b0, 32'h0, 16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd9, 64'd0, 32'h0, 1'b0, 32'h0, 16'd0));

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].vld, vecs[k].addr, vecs[k].data, vecs[k].clr);
      chk($sformatf("v%0d.ready", k), {63'd0, bus.wr_ready}, {63'd0, ~vecs[k].rst});
      chk($sformatf("v%0d.slice%0d", k, vecs[k].idx), regs_flat[vecs[k].idx*WIDTH +: WIDTH], vecs[k].e_slice);
      chk($sformatf("v%0d.onehot", k), {32'd0, wr_onehot}, {32'd0, vecs[k].e_oh});
      chk($sformatf("v%0d.pend_valid", k), {63'd0, pend_valid}, {63'd0, vecs[k].e_pv});
      chk($sformatf("v%0d.dirty", k), {32'd0, dirty}, {32'd0, vecs[k].e_dirty});
      chk($sformatf("v%0d.cnt", k), {48'd0, commit_cnt}, {48'd0, vecs[k].e_cnt});
      if (vecs[k].e_pv) begin
        chk($sformatf("v%0d.pend_addr", k), {59'd0, pend_addr}, {59'd0, vecs[k].addr});
        chk($sformatf("v%0d.pend_data", k), pend_data, vecs[k].data);
      end
    end

    // Test 6: 65535 back-to-back commits, then one more wraps the counter
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
    for (int n = 0; n < 65535; n++) begin
      drive(1'b0, 1'b1, n[4:0], 64'(n), 1'b0);
    end
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
    chk("wrap.pre_cnt", {48'd0, commit_cnt}, 64'h0000_0000_0000_FFFF);
    chk("wrap.slice0", regs_flat[0 +: WIDTH], 64'd65504);
`ifdef REGFILE_ZERO_REG_EN
    all_dirty = 32'h7FFF_FFFF;
`else
    all_dirty = 32'hFFFF_FFFF;
`endif
    chk("wrap.dirty", {32'd0, dirty}, {32'd0, all_dirty});
    drive(1'b0, 1'b1, 5'd0, 64'hABC, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
    chk("wrap.cnt", {48'd0, commit_cnt}, 64'd0);
    chk("wrap.slice0_new", regs_flat[0 +: WIDTH], 64'hABC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
Write side of the 32-entry register file. Accepts write requests over a valid/ready handshake and decodes the 5-bit destination into a one-hot enable (5:32 decoder). Commits data into the 32 storage registers one cycle after acceptance and exposes all registers flattened for the 32:1 read-mux columns. Also keeps a per-register dirty bitmap and a commit counter for context-save logic.

Parameters:
WIDTH, 64, data width of each register
CNT_W, 16, width of the commit counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
wr_valid  input  1  write request present
wr_ready  output  1  request accepted this cycle when wr_valid & wr_ready
wr_addr  input  5  destination register index
wr_data  input  WIDTH  data to write
regs_flat  output  32*WIDTH  register i at bits [i*WIDTH +: WIDTH]
wr_onehot  output  32  decoded enable of the committing stage, registered
pend_valid  output  1  stage-1 holds an uncommitted write
pend_addr  output  5  address of the pending write, for reader bypass
pend_data  output  WIDTH  data of the pending write
dirty  output  32  bit i set when register i has been written since last clear
clear_dirty  input  1  clears the dirty bitmap
commit_cnt  output  CNT_W  number of commits since reset

Behaviour:
- Reset: one synchronous, active-high reset. All registers = 0, pend_valid = 0, pend_addr = 0, pend_data = 0, wr_onehot = 0, dirty = 0, commit_cnt = 0. wr_ready = 0 during the reset cycle and 1 from the first cycle after it.
- Stage 1 (accept): on wr_valid & wr_ready, latch wr_addr/wr_data into pend_*. pend_valid <= 1.
- Stage 2 (commit): the cycle after acceptance, register[pend_addr] <= pend_data. wr_onehot = 1 << pend_addr for that cycle, otherwise 0. pend_valid clears unless a new request is accepted in the same cycle.
- Latency: accept at edge N, visible on regs_flat after edge N+1.
- Throughput: wr_ready is always 1 outside reset, so back-to-back writes sustain one write per cycle.
- Writes to the same address on consecutive cycles commit in order; the last one wins.
- Dirty bitmap: dirty[i] sets at the commit of register i.
  - clear_dirty clears all bits.
  - If clear_dirty and a commit coincide, the committing bit ends at 1 and all others at 0.
- Commit counter: commit_cnt increments by 1 per commit and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: a pending, uncommitted write is discarded. It is not written, not counted, and not marked dirty.
- Register values only change on a commit; there is no other write path.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 31 is hardwired to zero.
  - A write to address 31 is accepted and counted in commit_cnt.
  - It does not change storage and does not set dirty[31].
  - regs_flat slice 31 is always 0, and pend_valid is driven 0 for an address-31 request.
- Not defined: register 31 is ordinary storage.

Decomposition:
- Package regfile_pkg holds:
  - NUM_REGS = 32
  - ADDR_W = 5
  - ZERO_REG = 31
  - typedef reg_addr_t (logic [4:0])
- Sub-module decoder5_32 (5-bit index plus enable in, 32-bit one-hot out) is built as a tree of decoder2_4/decoder3_8. It is the structural mirror of the 32:1 read mux.

Test Plan:
1. Deassert reset, then write addr 5 data 0xDEAD_BEEF. Required response:
   - wr_onehot = 0x0000_0020 one cycle later.
   - regs_flat slice 5 = 0xDEAD_BEEF.
   - dirty = 0x0000_0020 and commit_cnt = 1.
2. Back-to-back writes, addr 3 = 0x11 then addr 3 = 0x22, on consecutive cycles. Required response:
   - wr_ready stays 1.
   - slice 3 reads 0x11 then 0x22.
   - commit_cnt = 2.
3. Write addr 31 = 0xFF. Required response:
   - With REGFILE_ZERO_REG_EN: slice 31 = 0, dirty[31] = 0, commit_cnt = 1.
   - Without it: slice 31 = 0xFF, dirty[31] = 1.
4. clear_dirty asserted in the same cycle as the commit to addr 7, with dirty = 0x0000_0F00 beforehand. Required response: dirty = 0x0000_0080.
5. Accept a write to addr 9 = 0x55, then assert reset on the next cycle. Required response: slice 9 = 0, pend_valid = 0, commit_cnt = 0 after reset.
6. Preload commit_cnt to 0xFFFF via 65535 writes (CNT_W = 16), then do one more write. Required response: commit_cnt = 0.
